proc_instr_feeder: RTL
======================

// Module: proc_instr_feeder
// PURPOSE
//  Upstream stage of the 9-bit processor: holds a loadable program memory and feeds
//  it, one instruction at a time, on the processor's DIN/Run inputs.
//  Uses the processor's Done output as the completion handshake.
//  Drives the MVI immediate word on DIN in the cycle after issue (processor T1).
//  Runs from address 0 up to ProgLen-1, then halts.
// PARAMETERS
//  W      9   instruction/data word width (iiixxxyyy)
//  DEPTH  32  program memory words
//  AW     5   address width, DEPTH = 2**AW
// PORTS
//  Clock      in   1     system clock, all state on posedge
//  Resetn     in   1     reset: synchronous, active-low
//  Start      in   1     level, sampled in IDLE/HALT: begin execution at address 0
//  LdEn       in   1     program memory write strobe (honoured only when Busy=0)
//  LdAddr     in   AW    write address
//  LdData     in   W     write data
//  ProgLen    in   AW+1  program length in words (0..DEPTH), sampled on Start
//  ProcDone   in   1     processor Done
//  DIN        out  W     to processor DIN
//  Run        out  1     to processor Run
//  Busy       out  1     1 from the Start acceptance edge until HALT
//  Halted     out  1     1 in HALT state
//  Err        out  1     sticky: MVI found at the last program word
//  PC         out  AW    address of next/current instruction
//  InstrCount out  8     instructions issued since Start, wraps mod 256
// BEHAVIOUR
//  Reset (Resetn=0 at posedge): FSM=IDLE. DIN=0, Run=0, Busy=0, Halted=0, Err=0,
//   PC=0, InstrCount=0, latched length=0. Memory contents are NOT cleared.
//   Reset mid-program aborts immediately; Run is low from the next cycle.
//  Memory: 1 write port, 1 async read port. LdEn while Busy=1 is ignored.
//  FSM:
//   IDLE/HALT: Run=0, DIN=0. On Start=1: latch ProgLen, PC=0, InstrCount=0, Err=0.
//    If ProgLen=0 -> HALT. Otherwise -> ISSUE, Busy=1.
//   ISSUE (1 cycle): Run=1, DIN=mem[PC], InstrCount+=1. Then -> GAP.
//   GAP (1 cycle): Run=0. ProcDone is ignored in this state.
//    If opcode mem[PC][8:6]=3'b001 (MVI): DIN=mem[PC+1], PC+=2.
//     If PC+1 >= len: DIN=0, Err=1, next state HALT.
//    Otherwise: DIN=0, PC+=1.
//    If no error -> WAIT.
//   WAIT: Run=0, DIN=0. On ProcDone=1:
//    PC >= len -> HALT (Busy=0, Halted=1); otherwise -> ISSUE.
//    Minimum period is 3 cycles per instruction (ISSUE, GAP, WAIT).
//  Start during Busy=1 is ignored. Start held high in HALT restarts the program.
//  PC arithmetic is computed in AW+1 bits for the >= len compare.
//   With len=DEPTH, the last instruction ends with PC=DEPTH (stored modulo, reads 0).
//  Run is never high for 2 consecutive cycles.
//  Run is never high while Resetn=0 or in HALT.
// TESTING
//  1. Load {MVI R0 (9'o100), 9'd5, MV R1,R0 (9'o010)}, ProgLen=3, Start.
//     Expect: Run pulses at 2 issue cycles, DIN=5 in the cycle after the first pulse.
//     Expect at end: Halted=1, InstrCount=2, PC=3, Err=0.
//  2. ADD program {9'o200} with ProcDone held low 4 extra cycles.
//     Expect: feeder stays in WAIT, no second Run, Halted only after ProcDone=1.
//  3. ProgLen=0, Start.
//     Expect: no Run pulse, Halted=1 next cycle, InstrCount=0.
//  4. ProgLen=1, mem[0]=9'o100 (MVI at last word).
//     Expect: one Run pulse, then Err=1 and Halted=1, DIN=0 in GAP.
//  5. Resetn=0 asserted in WAIT of a 3-instruction program.
//     Expect: all outputs at reset values next cycle.
//     Then restart: the same memory contents rerun correctly.
//  6. LdEn with LdAddr=0, LdData=9'o777 while Busy=1: mem[0] unchanged.
//     Start while Busy=1: no restart, PC sequence unaffected.

Source files
------------

// File: rtl/proc_instr_feeder_if.sv
// Handshake and load bus between the program feeder and its surroundings.
// The feeder side (slave) takes program/control inputs and drives the processor DIN/Run pins.
// The controller side (master) loads memory, starts runs and returns the processor's Done.
interface proc_instr_feeder_if #(
  parameter int W  = 9,
  parameter int AW = 5
);
  logic          Start;
  logic          LdEn;
  logic [AW-1:0] LdAddr;
  logic [W-1:0]  LdData;
  logic [AW:0]   ProgLen;
  logic          ProcDone;
  logic [W-1:0]  DIN;
  logic          Run;
  logic          Busy;
  logic          Halted;
  logic          Err;
  logic [AW-1:0] PC;
  logic [7:0]    InstrCount;

  modport slave (
    input  Start, LdEn, LdAddr, LdData, ProgLen, ProcDone,
    output DIN, Run, Busy, Halted, Err, PC, InstrCount
  );

  modport master (
    output Start, LdEn, LdAddr, LdData, ProgLen, ProcDone,
    input  DIN, Run, Busy, Halted, Err, PC, InstrCount
  );
endinterface

// File: rtl/proc_instr_feeder.sv
// Feeds a loadable program to the 9-bit processor one instruction at a time.
// Latency: Run pulses the cycle after Start is accepted; at least 3 cycles per instruction.
// Backpressure: waits in WAIT until the processor raises Done; loads are dropped while Busy.
module proc_instr_feeder #(
  parameter int W     = 9,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic              Clock,
  input logic              Resetn,
  proc_instr_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  logic [W-1:0] mem [DEPTH];

  state_t      state, state_nxt;
  // PC carries one extra bit so a program of exactly DEPTH words can reach PC=DEPTH.
  logic [AW:0] pc, pc_nxt;
  logic [AW:0] len, len_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        err, err_nxt;

  logic [W-1:0] din;
  logic         run;
  logic         busy;
  logic [AW:0]  pc_plus1;
  logic [W-1:0] cur_word;
  logic [W-1:0] imm_word;
  logic         is_mvi;

  assign busy     = (state == ISSUE) || (state == GAP) || (state == WAIT);
  assign pc_plus1 = pc + ONE;
  assign cur_word = mem[pc[AW-1:0]];
  assign imm_word = mem[pc_plus1[AW-1:0]];
  assign is_mvi   = (cur_word[W-1:W-3] == 3'b001);

  // Program memory write port; the program cannot be altered while it is running.
  always_ff @(posedge Clock) begin
    if (bus.LdEn && !busy) begin
      mem[bus.LdAddr] <= bus.LdData;
    end
  end

  // State and datapath registers, synchronous active-low reset (memory is kept).
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      pc    <= '0;
      len   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state and processor-pin decode: issue, then immediate word, then wait for Done.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    len_nxt   = len;
    cnt_nxt   = cnt;
    err_nxt   = err;
    din       = '0;
    run       = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (bus.Start) begin
          len_nxt   = bus.ProgLen;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (bus.ProgLen == '0) ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        run       = 1'b1;
        din       = cur_word;
        cnt_nxt   = cnt + 8'd1;
        state_nxt = GAP;
      end
      GAP: begin
        // Processor Done is deliberately not looked at here.
        if (is_mvi) begin
          pc_nxt = pc + TWO;
          if (pc_plus1 >= len) begin
            // Immediate word would lie past the end of the program.
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end else begin
            din       = imm_word;
            state_nxt = WAIT;
          end
        end else begin
          pc_nxt    = pc_plus1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.ProcDone) begin
          state_nxt = (pc >= len) ? HALT : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Processor pins are forced quiet whenever reset is held, even mid-cycle.
  assign bus.Run        = run & Resetn;
  assign bus.DIN        = Resetn ? din : '0;
  assign bus.Busy       = busy;
  assign bus.Halted     = (state == HALT);
  assign bus.Err        = err;
  assign bus.PC         = pc[AW-1:0];
  assign bus.InstrCount = cnt;

endmodule
